// File: rtl/hxmpp_seq_pkg.sv
// Shared types and sizing helpers for the hxmpp event sequencer.
package hxmpp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    DRAIN = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } seqState_t;

  localparam int unsigned SSIDBITS_DEF    = 16;
  localparam int unsigned HITINFOBITS_DEF = 16;

  // One extra bit so the counter can represent MAX itself.
  function automatic int unsigned creditWidth(input int unsigned maxVal);
    return $clog2(maxVal) + 1;
  endfunction

endpackage

// File: rtl/hxmpp_sequencer_credit.sv
// In-flight credit counter: counts issued-but-unfinished operations,
// flags completions that arrive with nothing outstanding.
module hxmpp_credit_counter
  import hxmpp_seq_pkg::*;
#(
  parameter  int unsigned MAX = 8,
  localparam int unsigned W   = creditWidth(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      underflow <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      // Stray completion: hold at zero and latch the error until reset.
      if (count == '0) underflow <= 1'b1;
      else             count     <= count - 1'b1;
    end
  end

  assign full = (count >= MAXV);

endmodule

// File: rtl/hxmpp_sequencer.sv
// Event-level controller for the hxmpp hit store: credit-limited hit writes,
// pipeline drain, credit-limited SSID reads, then an event-done pulse.
module hxmpp_sequencer
  import hxmpp_seq_pkg::*;
#(
  parameter int unsigned SSIDBITS      = SSIDBITS_DEF,
  parameter int unsigned HITINFOBITS   = HITINFOBITS_DEF,
  parameter int unsigned MAXWRINFLIGHT = 8,
  parameter int unsigned MAXRDINFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hit_valid,
  output logic                   hit_ready,
  input  logic [SSIDBITS-1:0]    hit_ssid,
  input  logic [HITINFOBITS-1:0] hit_info,
  input  logic                   hit_last,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [SSIDBITS-1:0]    rd_ssid,
  input  logic                   rd_last,
  output logic                   hx_write,
  output logic [SSIDBITS-1:0]    hx_writeSSID,
  output logic [HITINFOBITS-1:0] hx_writeHitInfo,
  output logic                   hx_read,
  output logic [SSIDBITS-1:0]    hx_readSSID,
  input  logic                   hx_writeReady,
  input  logic                   hx_readReady,
  input  logic                   hx_busy,
  input  logic                   hx_wrDone,
  input  logic                   hx_rdValid,
  input  logic [SSIDBITS-1:0]    hx_SSID_read,
  input  logic [HITINFOBITS-1:0] hx_hitInfo_read,
  output logic                   out_valid,
  output logic [SSIDBITS-1:0]    out_ssid,
  output logic [HITINFOBITS-1:0] out_hitinfo,
  output logic                   event_done,
  output logic [7:0]             event_count,
  output logic                   err_underflow,
  output logic [2:0]             state
);

  localparam int unsigned WRW = creditWidth(MAXWRINFLIGHT);
  localparam int unsigned RDW = creditWidth(MAXRDINFLIGHT);

  seqState_t      stateQ, stateD;
  logic           hitAccept, rdAccept;
  logic           rdLastSeen;
  logic           wrFull, rdFull;
  logic           wrUnderflow, rdUnderflow;
  logic [WRW-1:0] wrCnt;
  logic [RDW-1:0] rdCnt;

  assign hit_ready = (stateQ == WRITE) && hx_writeReady && !wrFull;
  assign rd_ready  = (stateQ == READ) && hx_readReady && !rdFull && !rdLastSeen;
  assign hitAccept = hit_valid && hit_ready;
  assign rdAccept  = rd_valid && rd_ready;

  hxmpp_credit_counter #(.MAX(MAXWRINFLIGHT)) uWrCredit (
    .clk       (clk),
    .reset     (reset),
    .inc       (hitAccept),
    .dec       (hx_wrDone),
    .count     (wrCnt),
    .full      (wrFull),
    .underflow (wrUnderflow)
  );

  hxmpp_credit_counter #(.MAX(MAXRDINFLIGHT)) uRdCredit (
    .clk       (clk),
    .reset     (reset),
    .inc       (rdAccept),
    .dec       (hx_rdValid),
    .count     (rdCnt),
    .full      (rdFull),
    .underflow (rdUnderflow)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (hit_valid) stateD = WRITE;
      WRITE:   if (hitAccept && hit_last) stateD = DRAIN;
      // hx_write covers a command still on its way to the store.
      DRAIN:   if (wrCnt == '0 && !hx_busy && !hx_write) stateD = READ;
      READ:    if (rdLastSeen && rdCnt == '0 && !hx_read) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ          <= IDLE;
      rdLastSeen      <= 1'b0;
      hx_write        <= 1'b0;
      hx_writeSSID    <= '0;
      hx_writeHitInfo <= '0;
      hx_read         <= 1'b0;
      hx_readSSID     <= '0;
      out_valid       <= 1'b0;
      out_ssid        <= '0;
      out_hitinfo     <= '0;
      event_done      <= 1'b0;
      event_count     <= '0;
    end else begin
      stateQ   <= stateD;
      hx_write <= hitAccept;
      if (hitAccept) begin
        hx_writeSSID    <= hit_ssid;
        hx_writeHitInfo <= hit_info;
      end
      hx_read <= rdAccept;
      if (rdAccept) hx_readSSID <= rd_ssid;
      out_valid <= hx_rdValid;
      if (hx_rdValid) begin
        out_ssid    <= hx_SSID_read;
        out_hitinfo <= hx_hitInfo_read;
      end
      if (stateQ == IDLE || stateQ == DONE) rdLastSeen <= 1'b0;
      else if (rdAccept && rd_last)         rdLastSeen <= 1'b1;
      // Registered from next-state so the pulse coincides with the DONE state.
      event_done <= (stateD == DONE);
      if (stateD == DONE) event_count <= event_count + 8'd1;
    end
  end

  assign err_underflow = wrUnderflow | rdUnderflow;
  assign state         = stateQ;

endmodule

// File: tb/tb_hxmpp_sequencer.sv
// Scoreboard bench for hxmpp_sequencer with an auto-responding hxmpp model.
module tb_hxmpp_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hit_valid, hit_ready, hit_last;
  logic [15:0] hit_ssid, hit_info;
  logic        rd_valid, rd_ready, rd_last;
  logic [15:0] rd_ssid;
  logic        hx_write, hx_read;
  logic [15:0] hx_writeSSID, hx_writeHitInfo, hx_readSSID;
  logic        hx_writeReady, hx_readReady, hx_busy, hx_wrDone;
  logic        hx_rdValid = 1'b0;
  logic [15:0] hx_SSID_read = '0, hx_hitInfo_read = '0;
  logic        out_valid, event_done, err_underflow;
  logic [15:0] out_ssid, out_hitinfo;
  logic [7:0]  event_count;
  logic [2:0]  state;

  hxmpp_sequencer #(
    .SSIDBITS(16), .HITINFOBITS(16), .MAXWRINFLIGHT(8), .MAXRDINFLIGHT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ssid(hit_ssid),
    .hit_info(hit_info), .hit_last(hit_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ssid(rd_ssid), .rd_last(rd_last),
    .hx_write(hx_write), .hx_writeSSID(hx_writeSSID), .hx_writeHitInfo(hx_writeHitInfo),
    .hx_read(hx_read), .hx_readSSID(hx_readSSID),
    .hx_writeReady(hx_writeReady), .hx_readReady(hx_readReady), .hx_busy(hx_busy),
    .hx_wrDone(hx_wrDone), .hx_rdValid(hx_rdValid),
    .hx_SSID_read(hx_SSID_read), .hx_hitInfo_read(hx_hitInfo_read),
    .out_valid(out_valid), .out_ssid(out_ssid), .out_hitinfo(out_hitinfo),
    .event_done(event_done), .event_count(event_count),
    .err_underflow(err_underflow), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] expWr[$];
  logic [15:0] expRd[$];
  logic [31:0] expOut[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Store model: done 4 cycles after each write, read data 2 cycles after each read.
  logic       autoWr = 1'b1, rdAuto = 1'b1, autoDone = 1'b0, manDone = 1'b0;
  logic [3:0] wrPipe = '0;
  logic [1:0] rdPipeV = '0;
  logic [15:0] rdPipeS [2];
  assign hx_wrDone = autoDone | manDone;

  always @(negedge clk) begin
    if (!reset) begin
      wrPipe = '0; rdPipeV = '0; autoDone = 1'b0; hx_rdValid = 1'b0;
    end else begin
      wrPipe = {wrPipe[2:0], hx_write};
      autoDone = autoWr && wrPipe[3];
      rdPipeV = {rdPipeV[0], hx_read};
      rdPipeS[1] = rdPipeS[0];
      rdPipeS[0] = hx_readSSID;
      hx_rdValid = rdAuto && rdPipeV[1];
      hx_SSID_read = rdPipeS[1];
      hx_hitInfo_read = rdPipeS[1] ^ 16'hA5A5;
    end
  end

  logic [7:0] modelEvents = '0;
  always @(negedge clk) begin
    if (!reset) begin
      modelEvents = '0;
    end else begin
      if (hx_write) begin
        if (expWr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_hx_write: got %0h/%0h expected none", hx_writeSSID, hx_writeHitInfo);
        end else chk("hx_write_payload", {hx_writeSSID, hx_writeHitInfo}, expWr.pop_front());
      end
      if (hx_read) begin
        if (expRd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_hx_read: got %0h expected none", hx_readSSID);
        end else chk("hx_read_ssid", 32'(hx_readSSID), 32'(expRd.pop_front()));
      end
      if (out_valid) begin
        if (expOut.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got %0h/%0h expected none", out_ssid, out_hitinfo);
        end else chk("out_data", {out_ssid, out_hitinfo}, expOut.pop_front());
      end
      if (event_done) begin
        modelEvents = modelEvents + 8'd1;
        chk("event_count_at_done", 32'(event_count), 32'(modelEvents));
      end
    end
  end

  task automatic sendHit(input logic [15:0] s, input logic [15:0] inf, input logic last,
                         output int waits);
    waits = 0;
    @(negedge clk);
    hit_valid = 1'b1; hit_ssid = s; hit_info = inf; hit_last = last;
    #1;
    while (!hit_ready && waits < 200) begin
      @(negedge clk); #1; waits++;
    end
    if (hit_ready) expWr.push_back({s, inf});
    else begin
      checks++; errors++;
      $display("FAIL hit_accept_timeout: ssid %0h got hit_ready 0 expected 1", s);
    end
    @(posedge clk);
    #1 hit_valid = 1'b0;
  endtask

  task automatic sendRd(input logic [15:0] s, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    rd_valid = 1'b1; rd_ssid = s; rd_last = last;
    #1;
    while (!rd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (rd_ready) begin
      expRd.push_back(s);
      expOut.push_back({s, s ^ 16'hA5A5});
    end else begin
      checks++; errors++;
      $display("FAIL rd_accept_timeout: ssid %0h got rd_ready 0 expected 1", s);
    end
    @(posedge clk);
    #1 rd_valid = 1'b0;
  endtask

  task automatic waitState(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (state !== st && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(state), 32'(st));
  endtask

  task automatic waitEvent(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (event_done !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(event_done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    hit_valid = 0; hit_ssid = '0; hit_info = '0; hit_last = 0;
    rd_valid = 0; rd_ssid = '0; rd_last = 0;
    hx_writeReady = 1; hx_readReady = 1; hx_busy = 0;

    #2 reset = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_hit_ready", 32'(hit_ready), 32'd0);
    chk("reset_outputs", {hx_write, hx_read, out_valid, event_done, err_underflow}, 32'd0);
    chk("reset_event_count", 32'(event_count), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Event 1: three hits back to back, two reads
    sendHit(16'd5, 16'h0A01, 1'b0, w);
    sendHit(16'd9, 16'h0A02, 1'b0, w);
    chk("hit2_no_stall", 32'(w), 32'd0);
    sendHit(16'd5, 16'h0A03, 1'b1, w);
    chk("hit3_no_stall", 32'(w), 32'd0);
    chk("state_drain_after_last", 32'(state), 32'd2);
    chk("hit_ready_closed_in_drain", 32'(hit_ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("drain_waits_last_done", 32'(state), 32'd2);
    waitState(3'd3, 20, "drain_to_read");
    sendRd(16'd5, 1'b0);
    sendRd(16'd9, 1'b1);
    chk("rd_ready_closed_after_last", 32'(rd_ready), 32'd0);
    waitEvent(50, "event1_done");
    chk("event_count_1", 32'(event_count), 32'd1);
    waitState(3'd0, 5, "idle_after_done");

    // Stray completion in IDLE
    chk("no_underflow_yet", 32'(err_underflow), 32'd0);
    @(negedge clk); manDone = 1'b1;
    @(negedge clk); manDone = 1'b0;
    #1 chk("underflow_set", 32'(err_underflow), 32'd1);
    repeat (5) @(negedge clk);
    chk("underflow_sticky", 32'(err_underflow), 32'd1);
    chk("idle_unchanged", 32'(state), 32'd0);

    // Credit limit: ten hits, completions withheld
    autoWr = 1'b0;
    for (int i = 0; i < 8; i++) sendHit(16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b0, w);
    chk("full_at_8", 32'(hit_ready), 32'd0);
    @(negedge clk);
    hit_valid = 1; hit_ssid = 16'h0108; hit_info = 16'h1008; hit_last = 0; manDone = 1'b1;
    #1 chk("full_during_done", 32'(hit_ready), 32'd0);
    @(negedge clk); manDone = 1'b0;
    #1 chk("one_slot_reopened", 32'(hit_ready), 32'd1);
    expWr.push_back({16'h0108, 16'h1008});
    @(posedge clk);
    @(negedge clk);
    #1 chk("only_one_slot", 32'(hit_ready), 32'd0);
    manDone = 1'b1;
    @(negedge clk);
    hit_ssid = 16'h0109; hit_info = 16'h1009; hit_last = 1;
    #1 chk("slot_after_second_done", 32'(hit_ready), 32'd1);
    expWr.push_back({16'h0109, 16'h1009});
    @(posedge clk);
    #1 hit_valid = 0; manDone = 1'b0;
    chk("drain_after_credit_last", 32'(state), 32'd2);
    repeat (6) begin @(negedge clk); manDone = 1'b1; end
    @(negedge clk); manDone = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_holds_one_left", 32'(state), 32'd2);
    @(negedge clk); manDone = 1'b1;
    @(negedge clk); manDone = 1'b0;
    waitState(3'd3, 10, "read_after_last_credit");
    autoWr = 1'b1;
    sendRd(16'h0100, 1'b0);
    sendRd(16'h0109, 1'b1);
    waitEvent(50, "event2_done");
    chk("event_count_2", 32'(event_count), 32'd2);

    // Reset with three reads outstanding
    sendHit(16'h0033, 16'h3300, 1'b1, w);
    waitState(3'd3, 30, "event3_read");
    rdAuto = 1'b0;
    sendRd(16'h0011, 1'b0);
    sendRd(16'h0012, 1'b0);
    sendRd(16'h0013, 1'b0);
    @(negedge clk);
    chk("read_before_reset", 32'(state), 32'd3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pulses", {hx_write, hx_read, out_valid, event_done, rd_ready, hit_ready}, 32'd0);
    chk("rst_readSSID", 32'(hx_readSSID), 32'd0);
    chk("rst_event_count", 32'(event_count), 32'd0);
    chk("rst_underflow", 32'(err_underflow), 32'd0);
    expOut.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rdAuto = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 32'(state), 32'd0);

    // 256 minimal events: counter wraps
    for (int e = 1; e <= 256; e++) begin
      sendHit(16'(e), 16'(e) ^ 16'hFFFF, 1'b1, w);
      sendRd(16'(e) + 16'h2000, 1'b1);
      waitEvent(60, "wrap_event_done");
      if (e == 255) chk("event_count_255", 32'(event_count), 32'd255);
      if (e == 256) chk("event_count_wrap", 32'(event_count), 32'd0);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(expWr.size() + expRd.size() + expOut.size()), 32'd0);
    chk("no_underflow_clean_events", 32'(err_underflow), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
